// File: rtl/ps2_keyboard.sv
// ============================================================================
// Module  : ps2_keyboard
// Brief   : PS/2 keyboard receiver: synchronise, deglitch, frame, check parity.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ps2_keyboard #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clock50,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_hit,
  output logic       ps2_err,
  output logic       busy
);

  localparam int FW = (FILTER > 1) ? $clog2(FILTER + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic          fclk_q, fclk_d, fclk_prev_q, fclk_prev_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [7:0]    data_q, data_d;
  logic          hit_q, hit_d;
  logic          err_q, err_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Front end flops idle high so reset release never looks like a falling edge.
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      dat_meta_q  <= 1'b1;
      dat_sync_q  <= 1'b1;
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      dat_meta_q  <= dat_meta_d;
      dat_sync_q  <= dat_sync_d;
      fclk_q      <= fclk_d;
      fclk_prev_q <= fclk_prev_d;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  always_comb begin
    clk_meta_d  = ps2_clk;
    clk_sync_d  = clk_meta_q;
    dat_meta_d  = ps2_dat;
    dat_sync_d  = dat_meta_q;
    fclk_prev_d = fclk_q;
    fclk_d      = fclk_q;
    filt_cnt_d  = '0;
    // Count consecutive cycles of disagreement; flip on the FILTER-th one.
    if (clk_sync_q != fclk_q) begin
      if (filt_cnt_q == FW'(FILTER - 1)) begin
        fclk_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = fclk_prev_q & ~fclk_q;

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      data_q    <= '0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      data_q    <= data_d;
      hit_q     <= hit_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    data_d    = data_q;
    hit_d     = 1'b0;
    err_d     = 1'b0;
    to_cnt_d  = '0;

    case (state_q)
      IDLE: begin
        if (fall && !dat_sync_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {dat_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = dat_sync_q;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (dat_sync_q && (^{shift_q, parity_q})) begin
            data_d = shift_q;
            hit_d  = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A falling edge in the terminal cycle takes priority over the timeout.
    if (state_q != IDLE && !fall) begin
      to_cnt_d = (to_cnt_q == TW'(TIMEOUT)) ? to_cnt_q : to_cnt_q + 1'b1;
      if (to_cnt_q == TW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end
  end

  assign ps2_data = data_q;
  assign ps2_hit  = hit_q;
  assign ps2_err  = err_q;
  assign busy     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
// ============================================================================
// Module  : tb_ps2_keyboard
// Brief   : Self-checking bench for ps2_keyboard (vector table + random frames).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_keyboard;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 1000;
  localparam int HALF    = 40;

  logic       clock50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] ps2_data;
  logic       ps2_hit, ps2_err, busy;

  ps2_keyboard #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock50 (clock50),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .ps2_data(ps2_data),
    .ps2_hit (ps2_hit),
    .ps2_err (ps2_err),
    .busy    (busy)
  );

  always #10 clock50 = ~clock50;

  int checks = 0, failures = 0;
  int hits = 0, errs = 0, both = 0, badchg = 0, busy_cyc = 0;
  logic [7:0] hit_log[$];
  logic [7:0] prev_data = 8'h00;

  always @(negedge clock50) begin
    if (ps2_hit) begin
      hits++;
      hit_log.push_back(ps2_data);
    end
    if (ps2_err) errs++;
    if (ps2_hit && ps2_err) both++;
    if (busy) busy_cyc++;
    if (reset_n && !ps2_hit && ps2_data !== prev_data) badchg++;
    prev_data = ps2_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame bit 0 is the start bit; data LSB first; odd parity unless flipped.
  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit flip, input bit stop);
    logic par;
    par = ~(^b) ^ flip;
    return {stop, par, b, 1'b0};
  endfunction

  // lat = negedges from the first raw falling edge to a hit/err in the low phase
  task automatic send(input logic [10:0] f, input int first, input int last, output int lat);
    lat = 0;
    for (int i = first; i <= last; i++) begin
      ps2_dat = f[i];
      repeat (HALF) @(negedge clock50);
      ps2_clk = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clock50);
        if (lat == 0 && (ps2_hit || ps2_err)) lat = k;
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic run_frame(input string name, input logic [10:0] f,
                           input int exp_hit, input int exp_err, input logic [7:0] exp_data);
    int h0, e0, lat;
    h0 = hits;
    e0 = errs;
    send(f, 0, 10, lat);
    repeat (20) @(negedge clock50);
    chk({name, "_hits"}, hits - h0, exp_hit);
    chk({name, "_errs"}, errs - e0, exp_err);
    chk({name, "_data"}, ps2_data, exp_data);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_latency"}, lat, FILTER + 3);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         flip;
    bit         stop;
    int         exp_hit;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, e0, b0, lat;
    logic [10:0] f;
    logic [7:0]  model_data;
    logic [7:0]  rb;
    bit          good;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1, 0, 8'hF0};
    vecs[2] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'hF0};
    vecs[3] = '{8'h59, 1'b0, 1'b0, 0, 1, 8'hF0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1, 0, 8'h00};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1, 0, 8'hFF};
    vecs[6] = '{8'hAA, 1'b1, 1'b0, 0, 1, 8'hFF};
    vecs[7] = '{8'h12, 1'b0, 1'b1, 1, 0, 8'h12};

    // Reset state
    repeat (3) @(negedge clock50);
    chk("rst_data", ps2_data, 8'h00);
    chk("rst_hit", ps2_hit, 1'b0);
    chk("rst_err", ps2_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    repeat (20) @(negedge clock50);
    chk("post_rst_busy", busy_cyc, 0);
    chk("post_rst_err", errs, 0);

    foreach (vecs[i]) begin
      run_frame($sformatf("vec%0d", i), mkframe(vecs[i].b, vecs[i].flip, vecs[i].stop),
                vecs[i].exp_hit, vecs[i].exp_err, vecs[i].exp_data);
    end

    // Back-to-back frames with no idle gap
    h0 = hits;
    send(mkframe(8'hF0, 1'b0, 1'b1), 0, 10, lat);
    send(mkframe(8'h12, 1'b0, 1'b1), 0, 10, lat);
    repeat (20) @(negedge clock50);
    chk("b2b_hits", hits - h0, 2);
    chk("b2b_first", (hit_log.size() > h0) ? hit_log[h0] : 8'hxx, 8'hF0);
    chk("b2b_second", (hit_log.size() > h0 + 1) ? hit_log[h0 + 1] : 8'hxx, 8'h12);

    // Timeout after 5 data bits, then a clean frame
    h0 = hits;
    e0 = errs;
    f = mkframe(8'h59, 1'b0, 1'b1);
    send(f, 0, 5, lat);
    chk("to_busy_mid", busy, 1'b1);
    repeat (TIMEOUT - 100) @(negedge clock50);
    chk("to_not_early", errs - e0, 0);
    repeat (300) @(negedge clock50);
    chk("to_err", errs - e0, 1);
    chk("to_busy_fall", busy, 1'b0);
    chk("to_no_hit", hits - h0, 0);
    run_frame("after_to", f, 1, 0, 8'h59);

    // Long but sub-timeout gap between two falling edges
    h0 = hits;
    e0 = errs;
    f = mkframe(8'h3C, 1'b0, 1'b1);
    send(f, 0, 3, lat);
    repeat (TIMEOUT - 200) @(negedge clock50);
    send(f, 4, 10, lat);
    repeat (20) @(negedge clock50);
    chk("gap_hits", hits - h0, 1);
    chk("gap_errs", errs - e0, 0);
    chk("gap_data", ps2_data, 8'h3C);

    // Glitch one cycle short of the filter length is ignored
    h0 = hits; e0 = errs; b0 = busy_cyc;
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (FILTER - 1) @(negedge clock50);
    ps2_clk = 1'b1;
    repeat (60) @(negedge clock50);
    ps2_dat = 1'b1;
    chk("glitch_busy", busy_cyc - b0, 0);
    chk("glitch_hits", hits - h0, 0);
    chk("glitch_errs", errs - e0, 0);

    // A low of exactly FILTER cycles is a real edge: start bit, then timeout
    e0 = errs; b0 = busy_cyc;
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (FILTER) @(negedge clock50);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clock50);
    ps2_dat = 1'b1;
    repeat (TIMEOUT + 100) @(negedge clock50);
    chk("edge_busy_seen", (busy_cyc - b0) > 0, 1'b1);
    chk("edge_timeout_err", errs - e0, 1);
    chk("edge_data_kept", ps2_data, 8'h3C);

    // Reset mid-frame discards the partial frame
    h0 = hits; e0 = errs;
    send(mkframe(8'h33, 1'b0, 1'b1), 0, 4, lat);
    reset_n = 1'b0;
    repeat (3) @(negedge clock50);
    chk("midrst_data", ps2_data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    reset_n = 1'b1;
    repeat (20) @(negedge clock50);
    run_frame("after_rst", mkframe(8'h12, 1'b0, 1'b1), 1, 0, 8'h12);
    chk("midrst_total_hits", hits - h0, 1);
    chk("midrst_total_errs", errs - e0, 0);

    // Random frames against a frame-level model
    model_data = 8'h12;
    for (int n = 0; n < 20; n++) begin
      rb = 8'($urandom);
      f = mkframe(rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0));
      good = f[10] && (^f[9:1]);
      if (good) model_data = rb;
      run_frame($sformatf("rnd%0d", n), f, good ? 1 : 0, good ? 0 : 1, model_data);
    end

    chk("never_hit_and_err", both, 0);
    chk("data_only_with_hit", badchg, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
